uart_receiver: RTL and testbench

- Serial UART receive front-end for the MIPS core: 8N1 frames, LSB first, mid-bit sampling.
- Sits directly upstream of the register file: rx_valid drives the register file's uart input, which mirrors it into bit 0 of $27.
- Software polls $27[0], reads rx_data through the peripheral path, then pulses rd_ack to release the buffer.

---
 rtl/uart_receiver.sv | 218 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive front-end with a one-byte holding buffer and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.

module uart_receiver #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t      state;
    state_t      state_next;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        cnt_clear;
    logic        tick_half;
    logic        tick_bit;
    logic        start_ok;
    logic        data_sample;
    logic        stop_sample;
    logic        good_stop;
    logic        bad_stop;
    logic        accept;

    // Two-flop synchroniser; the line idles high, so reset loads ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign tick_half = (cnt == HALF_LAST);
    assign tick_bit  = (cnt == BIT_LAST);

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick_half) begin
                    cnt_clear  = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_bit) begin
                    cnt_clear = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = AFTER_DATA;
                    end
                end
            end
            PARITY: begin
                if (tick_bit) begin
                    cnt_clear  = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick_bit) begin
                    cnt_clear  = 1'b1;
                    state_next = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                cnt_clear = 1'b1;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_clear  = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign start_ok    = (state == START) && tick_half && !rx_s;
    assign data_sample = (state == DATA) && tick_bit;
    assign stop_sample = (state == STOP) && tick_bit;
    assign good_stop   = stop_sample && rx_s;
    assign bad_stop    = stop_sample && !rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt_clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Data bits land LSB first at the index of the bit currently being sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state == IDLE || start_ok) begin
                bit_idx <= '0;
            end else if (data_sample) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (data_sample) begin
                shift[bit_idx] <= rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_sample;
    logic parity_mismatch;
    logic parity_bad;

    assign parity_sample   = (state == PARITY) && tick_bit;
    assign parity_mismatch = (rx_s != (^shift));

    // A bad parity bit poisons the frame; the stop bit can no longer rescue it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (parity_sample) begin
                parity_bad <= parity_mismatch;
            end
            if (parity_sample && parity_mismatch) begin
                parity_err <= 1'b1;
            end else if (rd_ack) begin
                parity_err <= 1'b0;
            end
        end
    end

    assign accept = good_stop && !parity_bad;
`else
    assign parity_err = 1'b0;
    assign accept     = good_stop;
`endif

    // Error sets win over rd_ack clears; a new byte wins over an acknowledge on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept && (!rx_valid || rd_ack)) begin
                rx_data <= shift;
            end
            if (accept) begin
                rx_valid <= 1'b1;
            end else if (rd_ack) begin
                rx_valid <= 1'b0;
            end
            if (accept && rx_valid && !rd_ack) begin
                overrun <= 1'b1;
            end else if (rd_ack) begin
                overrun <= 1'b0;
            end
            if (bad_stop) begin
                frame_err <= 1'b1;
            end else if (rd_ack) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver with CLKS_PER_BIT=16.
// Compile with UART_RX_PARITY_EN defined to exercise the parity build.

module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 10;
`else
    localparam int FRAME_BITS = 9;
`endif
    localparam int LAT_NOM   = 2 + HALF + FRAME_BITS * CPB;
    localparam int STOP_EDGE = 3 + HALF + FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int         cycle = 0;
    int         checks = 0;
    int         passes = 0;
    int         fall_cycle = 0;
    logic [7:0] exp_q[$];

    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] mon_exp;
    int         mon_lat;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rd_ack(rd_ack),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic holdBit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        holdBit(1'b1, n);
    endtask

    // One frame; called #1 after a posedge and returns #1 after a posedge.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic par_good);
        fall_cycle = cycle;
        holdBit(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdBit(data[i], CPB);
`ifdef UART_RX_PARITY_EN
        holdBit((^data) ^ !par_good, CPB);
`else
        if (!par_good) $display("[TB] note: parity request ignored in 8N1 build");
`endif
        holdBit(stop_bit, CPB);
    endtask

    task automatic pulseAck();
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        rd_ack = 1'b0;
    endtask

    // Monitor: a byte is presented when rx_valid rises or the buffered byte is replaced.
    always @(negedge clk) begin
        if (reset && rx_valid && (!prev_valid || rx_data != prev_data)) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("scoreboard_byte", rx_data, mon_exp);
            end
            if (!prev_valid) begin
                mon_lat = cycle - fall_cycle;
                checks++;
                if (mon_lat >= LAT_NOM - 1 && mon_lat <= LAT_NOM + 1) passes++;
                else $display("[TB] FAIL latency: got %0d cycles, expected %0d +/-1", mon_lat, LAT_NOM);
            end
        end
        prev_valid = rx_valid;
        prev_data  = rx_data;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_parity_err", parity_err, 0);
        reset = 1'b1;
        idle(5);

        $display("[TB] good frame 0x55");
        exp_q.push_back(8'h55);
        applyStimulus(8'h55, 1'b1, 1'b1);
        idle(4);
        checkOutput("t1_rx_valid", rx_valid, 1);
        checkOutput("t1_rx_data", rx_data, 8'h55);
        checkOutput("t1_frame_err", frame_err, 0);
        checkOutput("t1_overrun", overrun, 0);
        checkOutput("t1_parity_err", parity_err, 0);

        $display("[TB] start-bit glitch");
        holdBit(1'b0, 4);
        idle(30);
        checkOutput("glitch_rx_valid", rx_valid, 1);
        checkOutput("glitch_rx_data", rx_data, 8'h55);
        checkOutput("glitch_frame_err", frame_err, 0);
        checkOutput("glitch_overrun", overrun, 0);
        pulseAck();
        checkOutput("ack_rx_valid", rx_valid, 0);

        $display("[TB] framing error then break then 0x3C");
        applyStimulus(8'hA3, 1'b0, 1'b1);
        holdBit(1'b0, 40);
        idle(20);
        checkOutput("ferr_frame_err", frame_err, 1);
        checkOutput("ferr_rx_valid", rx_valid, 0);
        checkOutput("ferr_rx_data", rx_data, 8'h55);
        exp_q.push_back(8'h3C);
        applyStimulus(8'h3C, 1'b1, 1'b1);
        idle(4);
        checkOutput("after_break_rx_valid", rx_valid, 1);
        checkOutput("after_break_rx_data", rx_data, 8'h3C);
        checkOutput("after_break_frame_err_sticky", frame_err, 1);
        pulseAck();
        checkOutput("ferr_cleared", frame_err, 0);
        checkOutput("ferr_ack_rx_valid", rx_valid, 0);

        $display("[TB] overrun");
        exp_q.push_back(8'h11);
        applyStimulus(8'h11, 1'b1, 1'b1);
        idle(4);
        applyStimulus(8'h22, 1'b1, 1'b1);
        idle(4);
        checkOutput("ovr_rx_data", rx_data, 8'h11);
        checkOutput("ovr_overrun", overrun, 1);
        checkOutput("ovr_rx_valid", rx_valid, 1);
        pulseAck();
        checkOutput("ovr_ack_rx_valid", rx_valid, 0);
        checkOutput("ovr_ack_overrun", overrun, 0);

        $display("[TB] rd_ack on stop-sample cycle");
        exp_q.push_back(8'h11);
        applyStimulus(8'h11, 1'b1, 1'b1);
        idle(4);
        exp_q.push_back(8'h22);
        fork
            applyStimulus(8'h22, 1'b1, 1'b1);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                #1;
                rd_ack = 1'b1;
                @(posedge clk);
                #1;
                rd_ack = 1'b0;
            end
        join
        idle(4);
        checkOutput("coinc_rx_data", rx_data, 8'h22);
        checkOutput("coinc_rx_valid", rx_valid, 1);
        checkOutput("coinc_overrun", overrun, 0);
        pulseAck();

        $display("[TB] reset mid-frame");
        exp_q.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1, 1'b1);
        idle(4);
        holdBit(1'b0, CPB);
        for (int i = 0; i < 4; i++) holdBit(i[0], CPB);
        holdBit(1'b1, HALF);
        reset = 1'b0;
        #2;
        checkOutput("midreset_rx_data", rx_data, 8'h00);
        checkOutput("midreset_rx_valid", rx_valid, 0);
        checkOutput("midreset_frame_err", frame_err, 0);
        checkOutput("midreset_overrun", overrun, 0);
        checkOutput("midreset_parity_err", parity_err, 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(10);
        exp_q.push_back(8'h7E);
        applyStimulus(8'h7E, 1'b1, 1'b1);
        idle(4);
        checkOutput("post_reset_rx_valid", rx_valid, 1);
        checkOutput("post_reset_rx_data", rx_data, 8'h7E);
        checkOutput("post_reset_frame_err", frame_err, 0);
        checkOutput("post_reset_overrun", overrun, 0);
        checkOutput("post_reset_parity_err", parity_err, 0);
        pulseAck();

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity error");
        applyStimulus(8'h07, 1'b1, 1'b0);
        idle(4);
        checkOutput("par_parity_err", parity_err, 1);
        checkOutput("par_rx_valid", rx_valid, 0);
        pulseAck();
        checkOutput("par_ack_parity_err", parity_err, 0);
`endif

        $display("[TB] random bytes");
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            applyStimulus(b, 1'b1, 1'b1);
            idle($urandom_range(2, 20));
            checkOutput("rand_rx_valid", rx_valid, 1);
            checkOutput("rand_no_errors", {29'd0, frame_err, overrun, parity_err}, 0);
            pulseAck();
            checkOutput("rand_ack_rx_valid", rx_valid, 0);
            idle($urandom_range(0, 10));
        end

        idle(5);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
